// File: rtl/elevator_pkg.sv
`timescale 1ns/1ps
// Shared lift definitions: default geometry, door FSM states and a popcount helper.
package elevator_pkg;

   localparam int NUM_FLOORS_DEF = 4;
   localparam int FLOOR_W_DEF    = 2;

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      OPEN  = 2'd1,
      CLOSE = 2'd2
   } door_state_t;

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n = n + {31'b0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/floor_request_manager_if.sv
`timescale 1ns/1ps
// Controller-facing bundle: car status in, registered floor requests out.
interface floor_request_manager_if
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = NUM_FLOORS_DEF,
   parameter int FLOOR_W    = FLOOR_W_DEF
);
   logic [FLOOR_W-1:0]    current_floor;
   logic                  motor_stop;
   logic                  c_up;
   logic                  c_down;
   logic                  emergency_stop;
   logic [NUM_FLOORS-1:0] floor_req;

   modport master (
      output current_floor, motor_stop, c_up, c_down, emergency_stop,
      input  floor_req
   );

   modport slave (
      input  current_floor, motor_stop, c_up, c_down, emergency_stop,
      output floor_req
   );
endinterface

// File: rtl/floor_request_manager_btn_sync_edge.sv
`timescale 1ns/1ps
// Two-flop synchroniser for raw call buttons followed by a rising-edge detector.
module btn_sync_edge #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] btn,
   output logic [WIDTH-1:0] rise
);
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise = sync2 & ~prev;
endmodule

// File: rtl/floor_request_manager.sv
`timescale 1ns/1ps
// Floor request manager: latches call buttons as pending requests and runs the
// door dwell sequence when the car is stopped at a requested floor.
module floor_request_manager
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
   parameter int FLOOR_W      = FLOOR_W_DEF,
   parameter int DWELL_CYCLES = 8,
   parameter int CLOSE_CYCLES = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_FLOORS-1:0]           btn,
   floor_request_manager_if.slave          ctrl,
   output logic [NUM_FLOORS-1:0]           pending,
   output logic                            door_open,
   output logic                            door_closing,
   output logic [$clog2(NUM_FLOORS+1)-1:0] req_count
);
   localparam int MAX_CYC = (DWELL_CYCLES > CLOSE_CYCLES) ? DWELL_CYCLES : CLOSE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int REQ_W   = $clog2(NUM_FLOORS + 1);
   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLOSE_LOAD = CNT_W'(CLOSE_CYCLES - 1);

   door_state_t           state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [NUM_FLOORS-1:0] rise;
   logic [NUM_FLOORS-1:0] clr;
   logic [NUM_FLOORS-1:0] pending_nxt;
   logic [NUM_FLOORS-1:0] floor_mask;
   logic [FLOOR_W-1:0]    cur_floor;
   logic                  floor_ok;
   logic                  stopped;
   logic                  hold_here;

   btn_sync_edge #(.WIDTH(NUM_FLOORS)) u_sync (
      .clk   (clk),
      .reset (reset),
      .btn   (btn),
      .rise  (rise)
   );

   // One-hot of the car's floor; empty when the position is out of range so no service starts.
   assign cur_floor  = ctrl.current_floor;
   assign floor_ok   = int'(cur_floor) < NUM_FLOORS;
   assign floor_mask = floor_ok ? (NUM_FLOORS'(1) << cur_floor) : '0;
   assign hold_here  = |(rise & floor_mask);
   assign stopped    = ctrl.motor_stop & ~ctrl.c_up & ~ctrl.c_down & ~ctrl.emergency_stop;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr       = '0;
      if (!ctrl.emergency_stop) begin
         case (state)
            WAIT: begin
               if (stopped && |(pending & floor_mask)) begin
                  state_nxt = OPEN;
                  cnt_nxt   = DWELL_LOAD;
               end
            end
            OPEN: begin
               if (hold_here) begin
                  cnt_nxt = DWELL_LOAD;
               end else if (cnt == '0) begin
                  state_nxt = CLOSE;
                  cnt_nxt   = CLOSE_LOAD;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            CLOSE: begin
               // The clearing cycle takes precedence; a coincident press re-sets the bit below.
               if (cnt == '0) begin
                  clr       = floor_mask;
                  state_nxt = WAIT;
               end else if (hold_here) begin
                  state_nxt = OPEN;
                  cnt_nxt   = DWELL_LOAD;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            default: state_nxt = WAIT;
         endcase
      end
      pending_nxt = (pending & ~clr) | rise;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= WAIT;
         cnt            <= '0;
         pending        <= '0;
         ctrl.floor_req <= '0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         pending        <= pending_nxt;
         ctrl.floor_req <= (state_nxt == WAIT && !ctrl.emergency_stop) ? pending_nxt : '0;
      end
   end

   assign door_open    = (state == OPEN);
   assign door_closing = (state == CLOSE);
   assign req_count    = REQ_W'(popcount(32'(pending)));
endmodule

// File: tb/tb_floor_request_manager.sv
`timescale 1ns/1ps
// Randomised and directed bench for floor_request_manager against a cycle-level request/door model.
module tb_floor_request_manager;
   import elevator_pkg::*;

   localparam int NF = 4;
   localparam int FW = 2;
   localparam int DW = 8;
   localparam int CC = 2;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [NF-1:0]           btn = '0;
   logic [NF-1:0]           pending;
   logic                    door_open;
   logic                    door_closing;
   logic [$clog2(NF+1)-1:0] req_count;
   int                      total = 0;
   int                      bad = 0;
   bit                      run_chk = 1'b0;

   floor_request_manager_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) ctrl ();

   floor_request_manager #(
      .NUM_FLOORS(NF), .FLOOR_W(FW), .DWELL_CYCLES(DW), .CLOSE_CYCLES(CC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn          (btn),
      .ctrl         (ctrl),
      .pending      (pending),
      .door_open    (door_open),
      .door_closing (door_closing),
      .req_count    (req_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Reference model: btn history gives press events two edges late; the door phase
   // (0 idle, 1 open, 2 closing) carries the number of cycles it still has to run.
   logic [NF-1:0] h1, h2, h3, m_pend, m_freq, m_press, m_here, m_clr;
   int            m_phase, m_left;
   bit            m_stop, m_emer;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         h1 = '0; h2 = '0; h3 = '0;
         m_pend = '0; m_freq = '0;
         m_phase = 0; m_left = 0;
      end else begin
         m_press = h2 & ~h3;
         h3 = h2; h2 = h1; h1 = btn;
         m_here = (int'(ctrl.current_floor) < NF) ? (NF'(1) << ctrl.current_floor) : '0;
         m_emer = ctrl.emergency_stop;
         m_stop = ctrl.motor_stop && !ctrl.c_up && !ctrl.c_down && !m_emer;
         m_clr  = '0;
         if (!m_emer) begin
            if (m_phase == 0) begin
               if (m_stop && (m_pend & m_here) != '0) begin m_phase = 1; m_left = DW; end
            end else if (m_phase == 1) begin
               if ((m_press & m_here) != '0) m_left = DW;
               else if (m_left == 1) begin m_phase = 2; m_left = CC; end
               else m_left = m_left - 1;
            end else begin
               if (m_left == 1) begin m_clr = m_here; m_phase = 0; end
               else if ((m_press & m_here) != '0) begin m_phase = 1; m_left = DW; end
               else m_left = m_left - 1;
            end
         end
         m_pend = (m_pend & ~m_clr) | m_press;
         m_freq = (m_phase == 0 && !m_emer) ? m_pend : '0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run_chk && !reset) begin
         chk("model_pending", 32'(pending), 32'(m_pend));
         chk("model_floor_req", 32'(ctrl.floor_req), 32'(m_freq));
         chk("model_door_open", 32'(door_open), 32'(m_phase == 1));
         chk("model_door_closing", 32'(door_closing), 32'(m_phase == 2));
         chk("model_req_count", 32'(req_count), 32'($countones(m_pend)));
      end
   end

   task automatic press(input int b);
      @(posedge clk); #1 btn[b] = 1'b1;
      @(posedge clk); #1 btn[b] = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_open();
      bit ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (door_open) ok = 1'b1;
      end
      if (!ok) chk("wait_open_timeout", 32'(door_open), 32'h1);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (!door_open && !door_closing) ok = 1'b1;
      end
      if (!ok) chk("wait_idle_timeout", 32'({door_open, door_closing}), 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic count_run(input bit closing, output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         if (closing ? door_closing : door_open) n++;
         else break;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      int mode;
      ctrl.current_floor  = 2'd1;
      ctrl.motor_stop     = 1'b0;
      ctrl.c_up           = 1'b1;
      ctrl.c_down         = 1'b0;
      ctrl.emergency_stop = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      run_chk = 1'b1;
      @(negedge clk);
      chk("reset_pending", 32'(pending), 32'h0);
      chk("reset_door_open", 32'(door_open), 32'h0);
      chk("reset_floor_req", 32'(ctrl.floor_req), 32'h0);
      chk("reset_req_count", 32'(req_count), 32'h0);

      // Latch latency while moving: a three-cycle press appears two edges after first sample.
      @(posedge clk); #1 btn[2] = 1'b1;
      step(1);
      step(1);
      chk("latch_n1_pending", 32'(pending), 32'h0);
      @(posedge clk); #1 btn[2] = 1'b0;
      chk("latch_n2_pending", 32'(pending), 32'h4);
      chk("latch_n2_floor_req", 32'(ctrl.floor_req), 32'h4);
      chk("latch_n2_req_count", 32'(req_count), 32'h1);
      step(4);
      chk("latch_hold_once", 32'(pending), 32'h4);

      // motor_stop with c_up still high is not a stop.
      press(1);
      ctrl.motor_stop = 1'b1;
      step(10);
      chk("cup_no_service", 32'(door_open), 32'h0);
      chk("cup_pending", 32'(pending), 32'h6);

      // Press landing on the clearing edge at floor 1.
      ctrl.c_up = 1'b0;
      wait_open();
      repeat (7) @(posedge clk);
      #1 btn[1] = 1'b1;
      @(posedge clk); #1 btn[1] = 1'b0;
      step(2);
      chk("clrset_doors", 32'({door_open, door_closing}), 32'h0);
      chk("clrset_pending", 32'(pending), 32'h6);
      chk("clrset_floor_req", 32'(ctrl.floor_req), 32'h6);
      step(1);
      chk("clrset_reopen", 32'(door_open), 32'h1);
      chk("clrset_masked", 32'(ctrl.floor_req), 32'h0);
      wait_idle();

      // Service at floor 2; floor 3 stays pending.
      ctrl.c_up = 1'b1;
      ctrl.motor_stop = 1'b0;
      press(3);
      ctrl.current_floor = 2'd2;
      step(3);
      chk("moving_no_service", 32'(door_open), 32'h0);
      ctrl.c_up = 1'b0;
      ctrl.motor_stop = 1'b1;
      wait_open();
      count_run(1'b0, n);
      chk("svc_open_len", 32'(n), 32'd8);
      count_run(1'b1, n);
      chk("svc_close_len", 32'(n), 32'd2);
      chk("svc_pending", 32'(pending), 32'h8);
      chk("svc_floor_req", 32'(ctrl.floor_req), 32'h8);
      step(1);

      // Door-hold: press during OPEN reloads the dwell.
      press(2);
      wait_open();
      n = 1;
      for (int i = 1; i < 60; i++) begin
         @(posedge clk); #1;
         if (i == 1) btn[2] = 1'b1;
         if (i == 3) btn[2] = 1'b0;
         @(negedge clk);
         if (door_open) n++;
         else break;
      end
      chk("hold_open_len", 32'(n), 32'd12);
      wait_idle();

      // Press during CLOSE reopens the doors.
      press(2);
      wait_open();
      repeat (6) @(posedge clk);
      #1 btn[2] = 1'b1;
      @(posedge clk); #1 btn[2] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reopen_closing", 32'(door_closing), 32'h1);
      step(1);
      chk("reopen_open", 32'({door_open, door_closing}), 32'h2);
      wait_idle();

      // Emergency freeze at dwell count 3.
      press(2);
      wait_open();
      repeat (4) @(posedge clk);
      #1 ctrl.emergency_stop = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (i == 5) btn[0] = 1'b1;
         if (i == 6) btn[0] = 1'b0;
      end
      chk("emerg_door_held", 32'(door_open), 32'h1);
      chk("emerg_floor_req", 32'(ctrl.floor_req), 32'h0);
      chk("emerg_pending", 32'(pending), 32'hD);
      ctrl.emergency_stop = 1'b0;
      @(negedge clk);
      count_run(1'b0, n);
      chk("emerg_remaining", 32'(n), 32'd4);
      wait_idle();

      // Asynchronous reset in the middle of a dwell.
      #2 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      ctrl.c_up = 1'b1;
      ctrl.motor_stop = 1'b0;
      ctrl.current_floor = 2'd0;
      press(0);
      press(2);
      step(3);
      ctrl.c_up = 1'b0;
      ctrl.motor_stop = 1'b1;
      wait_open();
      chk("rstdwell_pending", 32'(pending), 32'h5);
      @(posedge clk); #2 reset = 1'b1;
      #1;
      chk("rstdwell_pending0", 32'(pending), 32'h0);
      chk("rstdwell_door0", 32'(door_open), 32'h0);
      chk("rstdwell_freq0", 32'(ctrl.floor_req), 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      step(5);
      chk("rstdwell_wait", 32'({door_open, door_closing}), 32'h0);

      // Randomised traffic checked cycle by cycle against the model.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if ($urandom_range(7) == 0) btn = NF'($urandom);
         if ($urandom_range(40) == 0) ctrl.current_floor = FW'($urandom);
         if ($urandom_range(20) == 0) begin
            mode = int'($urandom_range(5));
            ctrl.motor_stop = (mode <= 2) || (mode == 5);
            ctrl.c_up       = (mode == 3) || (mode == 5);
            ctrl.c_down     = (mode == 4);
         end
         if ($urandom_range(80) == 0) ctrl.emergency_stop = ~ctrl.emergency_stop;
      end
      btn = '0;
      step(3);
      run_chk = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
